// File: rtl/lif_pkg.sv
// lif_pkg: Q16.16 constants, scheduler state encoding and saturation helper
package lif_pkg;
    localparam logic [31:0] Q_ONE       = 32'h0001_0000;
    localparam logic [31:0] Q_MAX       = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN       = 32'h8000_0000;
    localparam logic [31:0] VTH_DEFAULT = 32'h0000_FC93;

    typedef enum logic [2:0] {IDLE, FETCH, CALC, WRITE, EMIT, DONE} state_t;

    function automatic logic [31:0] sat32(input logic signed [33:0] s);
        return s > $signed({2'b00, Q_MAX}) ? Q_MAX :
               s < $signed({2'b11, Q_MIN}) ? Q_MIN : s[31:0];
    endfunction
endpackage

// File: rtl/lif_sweep_scheduler_if.sv
// lif_sweep_if: tick/clear control, current fetch, spike and write-back streams
interface lif_sweep_if #(parameter int IDX_W = 8);
    logic             tick;
    logic             clr;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      cur_data;
    logic             spike_valid;
    logic [IDX_W-1:0] spike_id;
    logic             spike_ready;
    logic             v_valid;
    logic [IDX_W-1:0] v_idx;
    logic [31:0]      v_out;
    logic             busy;
    logic             overrun;

    modport master (
        input  tick, clr, cur_data, spike_ready,
        output cur_idx, spike_valid, spike_id, v_valid, v_idx, v_out, busy, overrun
    );
    modport slave (
        output tick, clr, cur_data, spike_ready,
        input  cur_idx, spike_valid, spike_id, v_valid, v_idx, v_out, busy, overrun
    );
endinterface

// File: rtl/lif_update_unit.sv
// lif_update_unit: multiplierless leaky-integrate step with saturation and threshold test
module lif_update_unit import lif_pkg::*; #(
    parameter int          LEAK_SHIFT = 3,
    parameter logic [31:0] VTH        = VTH_DEFAULT
) (
    input  logic [31:0] v,
    input  logic [31:0] cur,
    output logic [31:0] v_new,
    output logic        fire
);
    logic signed [32:0] d, step;
    logic signed [33:0] s;

    assign d     = $signed({cur[31], cur}) - $signed({v[31], v});
    assign step  = d >>> LEAK_SHIFT;
    assign s     = $signed({v[31], v[31], v}) + $signed({step[32], step});
    assign v_new = sat32(s);
    assign fire  = $signed(v_new) >= $signed(VTH);
endmodule

// File: rtl/lif_sweep_scheduler.sv
// lif_sweep_scheduler: sweeps one shared LIF datapath across NUM_NEURONS stored membranes per tick
module lif_sweep_scheduler import lif_pkg::*; #(
    parameter int          NUM_NEURONS  = 16,
    parameter int          IDX_W        = 8,
    parameter int          LEAK_SHIFT   = 3,
    parameter logic [31:0] VTH          = VTH_DEFAULT,
    parameter int          REFRAC_TICKS = 2
) (
    input logic         clk,
    input logic         rst,
    lif_sweep_if.master bus
);
    localparam int AW = $clog2(NUM_NEURONS);
    localparam int RW = REFRAC_TICKS > 0 ? $clog2(REFRAC_TICKS + 1) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
    logic [31:0]      cur_q, cur_d, vin_q, vin_d, sat_q, sat_d, upd_v, v_wr;
    logic             fire_q, fire_d, upd_fire, overrun_q, overrun_d;
    logic [31:0]      v_q [NUM_NEURONS];
    logic [31:0]      v_d [NUM_NEURONS];
    logic [RW-1:0]    refrac_q [NUM_NEURONS];
    logic [RW-1:0]    refrac_d [NUM_NEURONS];
    logic [AW-1:0]    ai;
    logic             last, in_refrac, spike;

    lif_update_unit #(.LEAK_SHIFT(LEAK_SHIFT), .VTH(VTH)) u_upd (
        .v(vin_q), .cur(cur_q), .v_new(upd_v), .fire(upd_fire)
    );

    assign ai        = idx_q[AW-1:0];
    assign last      = idx_q == IDX_W'(NUM_NEURONS - 1);
    assign nxt_idx   = last ? idx_q : idx_q + 1'b1;
    assign in_refrac = refrac_q[ai] != '0;
    assign spike     = !in_refrac && fire_q;
    // A refractory or firing neuron is written back as zero
    assign v_wr      = (in_refrac || fire_q) ? '0 : sat_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cur_d     = cur_q;
        vin_d     = vin_q;
        sat_d     = sat_q;
        fire_d    = fire_q;
        overrun_d = overrun_q || (bus.tick && state_q != IDLE);
        v_d       = v_q;
        refrac_d  = refrac_q;
        case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    v_d       = '{default: '0};
                    refrac_d  = '{default: '0};
                    overrun_d = 1'b0;
                end else if (bus.tick) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                cur_d   = bus.cur_data;
                vin_d   = v_q[ai];
                state_d = CALC;
            end
            CALC: begin
                sat_d   = upd_v;
                fire_d  = upd_fire;
                state_d = WRITE;
            end
            WRITE: begin
                v_d[ai]      = v_wr;
                refrac_d[ai] = in_refrac ? refrac_q[ai] - 1'b1 : fire_q ? RW'(REFRAC_TICKS) : refrac_q[ai];
                state_d      = spike ? EMIT : last ? DONE : FETCH;
                idx_d        = spike ? idx_q : nxt_idx;
            end
            EMIT: begin
                state_d = bus.spike_ready ? (last ? DONE : FETCH) : EMIT;
                idx_d   = bus.spike_ready ? nxt_idx : idx_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cur_q     <= '0;
            vin_q     <= '0;
            sat_q     <= '0;
            fire_q    <= 1'b0;
            overrun_q <= 1'b0;
            v_q       <= '{default: '0};
            refrac_q  <= '{default: '0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cur_q     <= cur_d;
            vin_q     <= vin_d;
            sat_q     <= sat_d;
            fire_q    <= fire_d;
            overrun_q <= overrun_d;
            v_q       <= v_d;
            refrac_q  <= refrac_d;
        end
    end

    assign bus.cur_idx     = idx_q;
    assign bus.spike_valid = state_q == EMIT;
    assign bus.spike_id    = idx_q;
    assign bus.v_valid     = state_q == WRITE;
    assign bus.v_idx       = idx_q;
    assign bus.v_out       = v_wr;
    assign bus.busy        = state_q != IDLE;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// tb_lif_sweep_scheduler: randomized sweeps scored against an arithmetic LIF reference model
module tb_lif_sweep_scheduler;
    import lif_pkg::*;
    localparam int N = 4, IDX_W = 8, LS = 3, RT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    lif_sweep_if #(.IDX_W(IDX_W)) bus();

    lif_sweep_scheduler #(
        .NUM_NEURONS(N), .IDX_W(IDX_W), .LEAK_SHIFT(LS), .VTH(VTH_DEFAULT), .REFRAC_TICKS(RT)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] idx; logic [31:0] v;} ev_t;
    ev_t         exp_v[$];
    int          exp_s[$];
    logic [31:0] cur_mem [N];
    logic [31:0] obs_v [N];
    longint      mv [N];
    int          mref [N];
    bit          m_ovr;
    int          bp, nsp, n_xfer, n_checks, n_fail, stall;
    ev_t         e;
    bit          prev_hold;
    logic [7:0]  prev_id;
    logic [31:0] prev_v;

    assign bus.cur_data = cur_mem[int'(bus.cur_idx) % N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // v + floor((cur - v) / 2^LS), clamped to the signed 32-bit range
    function automatic longint q_next(input longint v, input longint c);
        longint d = c - v;
        longint div = longint'(1) << LS;
        longint s = v + (d >= 0 ? d / div : -((-d + div - 1) / div));
        return s > 64'sh7FFFFFFF ? 64'sh7FFFFFFF : s < -64'sh80000000 ? -64'sh80000000 : s;
    endfunction

    task automatic model_neuron(input int i);
        longint s = q_next(mv[i], longint'($signed(cur_mem[i])));
        if (mref[i] > 0) begin
            mref[i]--;
            mv[i] = 0;
        end else if (s >= longint'($signed(VTH_DEFAULT))) begin
            mref[i] = RT;
            mv[i] = 0;
            exp_s.push_back(i);
            nsp++;
        end else mv[i] = s;
        exp_v.push_back({8'(i), 32'(mv[i])});
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mref[i] = 0;
        end
        m_ovr = 0;
    endtask

    task automatic run_sweep(input bit mid);
        int cnt = 0;
        int exp_cyc;
        nsp = 0;
        for (int i = 0; i < N; i++) model_neuron(i);
        exp_cyc = 3 * N + nsp * (1 + bp) + 1;
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
        while (bus.busy && cnt < 1000) begin
            cnt++;
            bus.tick = mid && cnt == 5;
            @(negedge clk);
        end
        bus.tick = 1'b0;
        if (mid) m_ovr = 1;
        check("sweep_cycles", cnt, exp_cyc);
        check("overrun", bus.overrun, m_ovr);
    endtask

    task automatic do_clr(input bit with_tick);
        @(negedge clk) begin bus.clr = 1'b1; bus.tick = with_tick; end
        @(negedge clk) begin bus.clr = 1'b0; bus.tick = 1'b0; end
        model_reset();
        check("clr_busy", bus.busy, 0);
        check("clr_overrun", bus.overrun, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.v_valid) begin
                if (exp_v.size() == 0) check("v_unexpected", 1, 0);
                else begin
                    e = exp_v.pop_front();
                    check("v_idx", bus.v_idx, e.idx);
                    check("v_out", bus.v_out, e.v);
                    obs_v[int'(bus.v_idx) % N] = bus.v_out;
                end
            end
            if (prev_hold) check("spike_hold", {bus.spike_valid, bus.spike_id}, {1'b1, prev_id});
            if (bus.spike_valid && bus.spike_ready) begin
                n_xfer++;
                if (exp_s.size() == 0) check("spike_unexpected", 1, 0);
                else check("spike_id", bus.spike_id, exp_s.pop_front());
            end
            prev_hold = bus.spike_valid && !bus.spike_ready;
            prev_id = bus.spike_id;
        end else prev_hold = 0;
    end

    initial begin
        bus.spike_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.spike_valid && stall < bp) begin
                bus.spike_ready = 1'b0;
                stall++;
            end else begin
                bus.spike_ready = 1'b1;
                if (!bus.spike_valid) stall = 0;
            end
        end
    end

    initial begin
        bus.tick = 1'b0;
        bus.clr = 1'b0;
        bp = 0;
        model_reset();
        foreach (cur_mem[i]) cur_mem[i] = Q_ONE;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.cur_idx, bus.spike_valid, bus.spike_id, bus.v_valid, bus.v_idx,
                                bus.v_out, bus.busy, bus.overrun}, '0);
        rst = 1'b1;

        run_sweep(0);
        check("s1_v0", obs_v[0], 32'h0000_2000);
        check("s1_v3", obs_v[3], 32'h0000_2000);
        run_sweep(0);
        check("s2_v1", obs_v[1], 32'h0000_3C00);
        check("no_spikes", n_xfer, 0);

        do_clr(0);
        foreach (cur_mem[i]) cur_mem[i] = '0;
        cur_mem[2] = 32'h0010_0000;
        run_sweep(0);
        check("refrac_s1", n_xfer, 1);
        check("refrac_s1_v2", obs_v[2], 0);
        run_sweep(0);
        run_sweep(0);
        check("refrac_s3", n_xfer, 1);
        run_sweep(0);
        check("refrac_s4", n_xfer, 2);

        do_clr(0);
        bp = 5;
        run_sweep(0);
        check("bp_xfer", n_xfer, 3);
        bp = 0;

        run_sweep(1);
        repeat (3) @(negedge clk);
        check("overrun_sticky", bus.overrun, 1);
        do_clr(1);
        foreach (cur_mem[i]) cur_mem[i] = '0;
        run_sweep(0);
        check("clr_v2", obs_v[2], 0);

        foreach (cur_mem[i]) cur_mem[i] = Q_MIN;
        prev_v = '0;
        repeat (40) begin
            run_sweep(0);
            check("sat_mono", $signed(obs_v[0]) <= $signed(prev_v), 1);
            check("sat_no_wrap", obs_v[0][31], 1);
            prev_v = obs_v[0];
        end

        repeat (30) begin
            foreach (cur_mem[i])
                cur_mem[i] = ($urandom_range(0, 3) == 0) ? $urandom()
                           : 32'($urandom_range(0, 32'h0006_0000)) - 32'h0002_0000;
            bp = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) do_clr(0);
            run_sweep($urandom_range(0, 3) == 0);
        end

        do_clr(0);
        bp = 0;
        foreach (cur_mem[i]) cur_mem[i] = Q_ONE;
        nsp = 0;
        model_neuron(0);
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_idx", bus.cur_idx, 1);
        rst = 1'b0;
        #1;
        check("rst_outputs", {bus.cur_idx, bus.spike_valid, bus.spike_id, bus.v_valid, bus.v_idx,
                              bus.v_out, bus.busy, bus.overrun}, '0);
        model_reset();
        exp_v.delete();
        exp_s.delete();
        @(negedge clk) rst = 1'b1;
        run_sweep(0);
        check("post_rst_v0", obs_v[0], 32'h0000_2000);
        check("post_rst_v3", obs_v[3], 32'h0000_2000);

        check("exp_v_drained", exp_v.size(), 0);
        check("exp_s_drained", exp_s.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
